fm_op_seq: RTL and testbench

- Operator sequencer that sits directly upstream of the envelope generator and operator datapath.
- Once per sample tick, it sweeps every operator slot in order and drives op_sel to the shared per-operator state RAMs.
- On the last cycle of each slot it issues a one-cycle next strobe, together with the slot's restart and op_reset qualifiers.
- It tracks the previous key-on state of every operator, so restart fires only on a key-on rising edge. It also arbitrates a global voice-clear request.

---
 rtl/fm_pkg.sv | 22 ++
 rtl/fm_op_seq.sv | 147 ++++++++++++++
 tb/tb_fm_op_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// Shared FM synthesis definitions.
// Holds the operator-sequencer FSM encoding and the default slot timing
// constants, which are also used by the envelope generator's timing.
package fm_pkg;

  localparam int NUM_OPS_MAX       = 64;
  localparam int NUM_OPS_DEF       = 36;
  localparam int CYCLES_PER_OP_DEF = 4;
  localparam int OP_SEL_W          = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Clocks from the starting tick to the end of the DONE cycle.
  function automatic int sweep_cycles(input int n_ops, input int cyc_per_op);
    return n_ops * cyc_per_op + 1;
  endfunction

endpackage

// File: rtl/fm_op_seq.sv
// Operator sequencer.
// On each sample tick, steps op_sel through every operator slot. Each slot
// lasts CYCLES_PER_OP clocks. On the last clock of a slot it raises next,
// together with the slot's restart and op_reset qualifiers.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   tick        - sample strobe; starts a sweep (one pending tick queued)
//   clr_req     - request to reset all operators during the next sweep
//   kon         - key-on of the operator at op_sel (valid from slot cycle 1)
//   op_sel      - current operator index
//   next        - one-cycle commit strobe on the last cycle of each slot
//   restart     - key-on rising edge for the current operator (with next)
//   op_reset    - force the current operator to reset (with next)
//   busy        - sweep in progress
//   sweep_done  - one-cycle pulse after the final slot
//   overrun     - sticky flag: a tick was dropped
module fm_op_seq
  import fm_pkg::*;
#(
  parameter int NUM_OPS       = NUM_OPS_DEF,
  parameter int CYCLES_PER_OP = CYCLES_PER_OP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                clr_req,
  input  logic                kon,
  output logic [OP_SEL_W-1:0] op_sel,
  output logic                next,
  output logic                restart,
  output logic                op_reset,
  output logic                busy,
  output logic                sweep_done,
  output logic                overrun
);

  localparam int CW = (CYCLES_PER_OP > 1) ? $clog2(CYCLES_PER_OP) : 1;
  localparam logic [CW-1:0]       CYC_LAST = CW'(CYCLES_PER_OP - 1);
  // next is raised one cycle early so it is registered yet aligned with the last slot cycle.
  localparam logic [CW-1:0]       CYC_ARM  = CW'(CYCLES_PER_OP - 2);
  localparam logic [OP_SEL_W-1:0] OP_LAST  = OP_SEL_W'(NUM_OPS - 1);

  seq_state_t          state_reg;
  logic [OP_SEL_W-1:0] op_sel_reg;
  logic [CW-1:0]       cyc_reg;
  logic                next_reg;
  logic                op_reset_reg;
  logic                busy_reg;
  logic                sweep_done_reg;
  logic                overrun_reg;
  logic                tick_pend_reg;
  logic                clr_pend_reg;
  logic                clr_act_reg;
  logic [NUM_OPS-1:0]  kon_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_sel_reg     <= '0;
      cyc_reg        <= '0;
      next_reg       <= 1'b0;
      op_reset_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      sweep_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      tick_pend_reg  <= 1'b0;
      clr_pend_reg   <= 1'b0;
      clr_act_reg    <= 1'b0;
      kon_prev_reg   <= '0;
    end else begin
      sweep_done_reg <= 1'b0;
      if (clr_req) clr_pend_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (tick || tick_pend_reg) begin
            state_reg     <= ST_RUN;
            op_sel_reg    <= '0;
            cyc_reg       <= '0;
            busy_reg      <= 1'b1;
            tick_pend_reg <= 1'b0;
            // A clear request that arrives in this same cycle waits for the following sweep.
            clr_act_reg   <= clr_pend_reg;
            clr_pend_reg  <= clr_req;
          end
        end

        ST_RUN: begin
          if (tick) begin
            if (tick_pend_reg) overrun_reg   <= 1'b1;
            else               tick_pend_reg <= 1'b1;
          end
          if (cyc_reg == CYC_LAST) begin
            next_reg     <= 1'b0;
            op_reset_reg <= 1'b0;
            // A clearing sweep forgets the key state so held keys retrigger afterwards.
            kon_prev_reg[op_sel_reg] <= kon & ~clr_act_reg;
            cyc_reg      <= '0;
            if (op_sel_reg == OP_LAST) begin
              state_reg      <= ST_DONE;
              op_sel_reg     <= '0;
              busy_reg       <= 1'b0;
              sweep_done_reg <= 1'b1;
              clr_act_reg    <= 1'b0;
            end else begin
              op_sel_reg <= op_sel_reg + OP_SEL_W'(1);
            end
          end else begin
            cyc_reg <= cyc_reg + CW'(1);
            if (cyc_reg == CYC_ARM) begin
              next_reg     <= 1'b1;
              op_reset_reg <= clr_act_reg;
            end
          end
        end

        ST_DONE: begin
          if (tick || tick_pend_reg) begin
            if (tick && tick_pend_reg) overrun_reg <= 1'b1;
            state_reg     <= ST_RUN;
            op_sel_reg    <= '0;
            cyc_reg       <= '0;
            busy_reg      <= 1'b1;
            tick_pend_reg <= 1'b0;
            clr_act_reg   <= clr_pend_reg;
            clr_pend_reg  <= clr_req;
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // kon is a register-file read that is only known in the next cycle itself, so the
  // edge detect is combinational and gated by the registered next.
  assign restart    = next_reg & ~clr_act_reg & kon & ~kon_prev_reg[op_sel_reg];
  assign op_sel     = op_sel_reg;
  assign next       = next_reg;
  assign op_reset   = op_reset_reg;
  assign busy       = busy_reg;
  assign sweep_done = sweep_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fm_op_seq.sv
// Self-checking bench for fm_op_seq. It uses a sweep-level reference model:
// the expected slot/strobe pattern is computed from the cycle offset since
// the tick, and key-on edges come from a per-operator key table.
module tb_fm_op_seq;
  import fm_pkg::*;

  localparam int N = NUM_OPS_DEF;
  localparam int C = CYCLES_PER_OP_DEF;
  localparam int L = sweep_cycles(NUM_OPS_DEF, CYCLES_PER_OP_DEF);

  logic       clk = 1'b0;
  logic       rst_n, tick, clr_req, kon;
  logic [5:0] op_sel;
  logic       next, restart, op_reset, busy, sweep_done, overrun;

  bit kon_tab [64];
  bit prev_m  [64];
  bit pend_m, clr_pend_m, ovr_m;
  int n_chk, n_pass, sweep_id, last_restarts;

  always #5 clk = ~clk;

  always_comb kon = kon_tab[op_sel];

  fm_op_seq #(.NUM_OPS(N), .CYCLES_PER_OP(C)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clr_req(clr_req), .kon(kon),
    .op_sel(op_sel), .next(next), .restart(restart), .op_reset(op_reset),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [11:0] outs();
    return {overrun, sweep_done, busy, op_reset, restart, next, op_sel};
  endfunction

  task automatic model_reset();
    foreach (prev_m[i]) prev_m[i] = 1'b0;
    pend_m = 0; clr_pend_m = 0; ovr_m = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = 0; clr_req = 0;
      chk("idle", 32'(outs()), 32'({ovr_m, 11'b0}));
    end
  endtask

  // Drives the starting tick in an idle cycle (cycle 0 of the sweep).
  task automatic start(input bit with_clr);
    idle(1);
    tick = 1; clr_req = with_clr;
  endtask

  // Checks one whole sweep cycle by cycle. ta/tb/ca are cycle offsets at
  // which to inject an extra tick / clr_req (-1 for none).
  task automatic check_sweep(input bit start_clr, input int ta, input int tb,
                             input int ca, output bit chained);
    bit clr_act_m;
    int restarts;
    clr_act_m  = clr_pend_m;
    clr_pend_m = start_clr;
    pend_m     = 0;
    restarts   = 0;
    for (int k = 1; k <= L; k++) begin
      int  op;
      bit  nxt, rs, orst, bsy, dn;
      @(negedge clk);
      tick = 0; clr_req = 0;
      if (k < L) begin
        op   = (k - 1) / C;
        nxt  = (k % C) == 0;
        rs   = nxt && !clr_act_m && kon_tab[op] && !prev_m[op];
        orst = nxt && clr_act_m;
        bsy  = 1; dn = 0;
      end else begin
        op = 0; nxt = 0; rs = 0; orst = 0; bsy = 0; dn = 1;
      end
      chk($sformatf("sw%0d_c%0d", sweep_id, k), 32'(outs()),
          32'({ovr_m, dn, bsy, orst, rs, nxt, 6'(op)}));
      if (rs) restarts++;
      if (nxt) prev_m[op] = clr_act_m ? 1'b0 : kon_tab[op];
      if (k == ta || k == tb) begin
        tick = 1;
        if (pend_m) ovr_m = 1; else pend_m = 1;
      end
      if (k == ca) begin
        clr_req = 1; clr_pend_m = 1;
      end
    end
    chained = pend_m;
    last_restarts = restarts;
    $display("sweep %0d: clear=%0b restarts=%0d chained=%0b overrun=%0b",
             sweep_id, clr_act_m, restarts, chained, overrun);
    sweep_id++;
  endtask

  task automatic run(input bit sclr, input int ta, input int tb, input int ca);
    bit ch;
    start(sclr);
    check_sweep(sclr, ta, tb, ca, ch);
    while (ch) check_sweep(1'b0, -1, -1, -1, ch);
  endtask

  task automatic set_kon_only(input int op, input bit v);
    foreach (kon_tab[i]) kon_tab[i] = 1'b0;
    kon_tab[op] = v;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; sweep_id = 0;
    rst_n = 0; tick = 0; clr_req = 0;
    foreach (kon_tab[i]) kon_tab[i] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'd0);
    rst_n = 1;
    idle(2);

    // Plain sweep, all keys off.
    run(0, -1, -1, -1);
    chk("kon0_restarts", 32'(last_restarts), 32'd0);

    // Op 5 held on for two sweeps, then 1,0,1 pattern.
    set_kon_only(5, 1);
    run(0, -1, -1, -1);
    chk("op5_first", 32'(last_restarts), 32'd1);
    run(0, -1, -1, -1);
    chk("op5_held", 32'(last_restarts), 32'd0);
    set_kon_only(5, 0);
    run(0, -1, -1, -1);
    set_kon_only(5, 1);
    run(0, -1, -1, -1);
    chk("op5_again", 32'(last_restarts), 32'd1);

    // Clear request during op 10; op 3 key held across three sweeps.
    set_kon_only(3, 1);
    run(0, -1, -1, 10 * C + 2);
    run(0, -1, -1, -1);
    chk("clr_no_restart", 32'(last_restarts), 32'd0);
    run(0, -1, -1, -1);
    chk("after_clr_op3", 32'(last_restarts), 32'd1);

    // Randomized key tables, clear timing and idle gaps.
    for (int s = 0; s < 6; s++) begin
      bit sclr;
      int ca;
      foreach (kon_tab[i]) kon_tab[i] = 1'($urandom_range(0, 1));
      sclr = ($urandom % 4) == 0;
      ca   = (($urandom % 3) == 0) ? int'($urandom_range(1, L - 2)) : -1;
      run(sclr, -1, -1, ca);
      idle(int'($urandom_range(1, 5)));
    end

    // Tick at 50 queues a back-to-back sweep, tick at 60 is dropped.
    foreach (kon_tab[i]) kon_tab[i] = 1'($urandom_range(0, 1));
    run(0, 50, 60, -1);
    chk("overrun_set", 32'(overrun), 32'd1);
    idle(3);

    // Asynchronous reset in the middle of op 20.
    start(0);
    repeat (20 * C + 1) begin
      @(negedge clk);
      tick = 0;
    end
    chk("op_sel_before_rst", 32'(op_sel), 32'd20);
    rst_n = 0;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'd0);
    model_reset();
    @(negedge clk);
    chk("rst_held_outs", 32'(outs()), 32'd0);
    rst_n = 1;
    idle(2);
    foreach (kon_tab[i]) kon_tab[i] = 1'b1;
    run(0, -1, -1, -1);
    chk("post_rst_restarts", 32'(last_restarts), 32'(N));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
